// File: rtl/msk_rnd_pkg.sv
// Shared types and sizing for the masked-randomness feeder: HPC2 rnd width helper,
// default geometry and the feeder FSM state encoding.
package msk_rnd_pkg;

   function automatic int hpc2rnd(input int shares);
      return shares * (shares - 1) / 2;
   endfunction

   localparam int D_DEF        = 2;
   localparam int NGADGETS_DEF = 4;
   localparam int OUT_W        = NGADGETS_DEF * hpc2rnd(D_DEF);
   localparam int CAP          = 2 * OUT_W;

   typedef enum logic [1:0] {
      RST   = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } fsm_state_t;

endpackage

// File: rtl/rnd_shift_buf.sv
// Bit buffer, bit 0 oldest: consume drops the low OW bits, push appends IN_W bits at the
// fill point; both together in one cycle. Next-state fill is exported for the FSM.
module rnd_shift_buf #(
   parameter int OW   = 4,
   parameter int CW   = 8,
   parameter int IN_W = 3,
   parameter int FW   = 4
) (
   input  logic            clk,
   input  logic            syn_rstn,
   input  logic            push,
   input  logic [IN_W-1:0] push_dat,
   input  logic            consume,
   output logic [OW-1:0]   out_word,
   output logic [FW-1:0]   fill,
   output logic [FW-1:0]   fill_nxt
);

   logic [CW-1:0] buf_q, buf_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [CW-1:0] base_buf;
   logic [FW-1:0] base_fill;
   logic [CW-1:0] ins;

   // Bits at and above fill are always zero, so an insert is a plain OR.
   always_comb begin
      base_buf  = buf_q;
      base_fill = fill_q;
      ins       = {{(CW-IN_W){1'b0}}, push_dat};
      if (consume) begin
         base_buf  = buf_q >> OW;
         base_fill = fill_q - FW'(OW);
      end
      buf_d  = base_buf;
      fill_d = base_fill;
      if (push) begin
         buf_d  = base_buf | (ins << base_fill);
         fill_d = base_fill + FW'(IN_W);
      end
   end

   always_ff @(posedge clk) begin
      if (!syn_rstn) begin
         buf_q  <= '0;
         fill_q <= '0;
      end else begin
         buf_q  <= buf_d;
         fill_q <= fill_d;
      end
   end

   assign out_word = buf_q[OW-1:0];
   assign fill     = fill_q;
   assign fill_nxt = fill_d;

endmodule

// File: rtl/msk_rnd_feeder.sv
// PRNG-to-HPC2 rnd width adapter: primes a 2*OUT_W buffer, then serves one fresh word per out_req.
// in_ready/out_valid depend on registered state only; optional stuck detector under RND_STUCK_DETECT_EN.
module msk_rnd_feeder
   import msk_rnd_pkg::*;
#(
   parameter int d        = D_DEF,
   parameter int NGADGETS = NGADGETS_DEF,
   parameter int IN_W     = 3,
   localparam int OW      = NGADGETS * hpc2rnd(d),
   localparam int CW      = 2 * OW,
   localparam int FW      = $clog2(CW + 1)
) (
   input  logic            clk,
   input  logic            syn_rstn,
   input  logic [IN_W-1:0] in_rnd,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            out_req,
   output logic [OW-1:0]   out_rnd,
   output logic            out_valid,
`ifdef RND_STUCK_DETECT_EN
   output logic            stuck,
`endif
   output logic            underflow
);

   if (IN_W < 1 || IN_W > OW) begin : g_bad_in_w
      $error("msk_rnd_feeder: IN_W must lie in 1..OUT_W");
   end

   fsm_state_t    state_q, state_d;
   logic          underflow_q, underflow_d;
   logic          push, consume;
   logic [OW-1:0] word;
   logic [FW-1:0] fill, fill_nxt;

   assign in_ready  = (state_q != RST) && (fill <= FW'(CW - IN_W));
   assign out_valid = (state_q == RUN) && (fill >= FW'(OW));
   assign out_rnd   = out_valid ? word : '0;
   assign underflow = underflow_q;
   assign push      = in_valid && in_ready;
   assign consume   = out_req && out_valid;

   rnd_shift_buf #(
      .OW   (OW),
      .CW   (CW),
      .IN_W (IN_W),
      .FW   (FW)
   ) u_buf (
      .clk      (clk),
      .syn_rstn (syn_rstn),
      .push     (push),
      .push_dat (in_rnd),
      .consume  (consume),
      .out_word (word),
      .fill     (fill),
      .fill_nxt (fill_nxt)
   );

   // Serving starts only once the buffer is too full for another beat.
   always_comb begin
      state_d     = state_q;
      underflow_d = underflow_q | (out_req & ~out_valid);
      case (state_q)
         RST:     state_d = PRIME;
         PRIME:   if (fill_nxt >= FW'(CW - IN_W + 1)) state_d = RUN;
         RUN:     if (consume && (fill_nxt < FW'(OW))) state_d = PRIME;
         default: state_d = RST;
      endcase
   end

`ifdef RND_STUCK_DETECT_EN
   logic [IN_W-1:0] last_q, last_d;
   logic [1:0]      run_q, run_d;
   logic            stuck_q, stuck_d;

   // run_q is the current run length of identical accepted beats, 0 meaning none yet.
   always_comb begin
      last_d  = last_q;
      run_d   = run_q;
      stuck_d = stuck_q;
      if (push) begin
         last_d = in_rnd;
         if ((run_q != 2'd0) && (in_rnd == last_q)) begin
            if (run_q == 2'd3) stuck_d = 1'b1;
            else               run_d   = run_q + 2'd1;
         end else begin
            run_d = 2'd1;
         end
      end
   end

   assign stuck = stuck_q;
`endif

   always_ff @(posedge clk) begin
      if (!syn_rstn) begin
         state_q     <= RST;
         underflow_q <= 1'b0;
`ifdef RND_STUCK_DETECT_EN
         last_q      <= '0;
         run_q       <= 2'd0;
         stuck_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         underflow_q <= underflow_d;
`ifdef RND_STUCK_DETECT_EN
         last_q      <= last_d;
         run_q       <= run_d;
         stuck_q     <= stuck_d;
`endif
      end
   end

endmodule

// File: tb/tb_msk_rnd_feeder.sv
// Bench for msk_rnd_feeder: bit-queue reference model checked every cycle, plus directed literals.
module tb_msk_rnd_feeder;
   import msk_rnd_pkg::*;

   localparam int IN_W = 3;
   localparam int OW   = OUT_W;
   localparam int CW   = CAP;

   logic            clk;
   logic            syn_rstn;
   logic [IN_W-1:0] in_rnd;
   logic            in_valid;
   logic            in_ready;
   logic            out_req;
   logic [OW-1:0]   out_rnd;
   logic            out_valid;
   logic            underflow;
`ifdef RND_STUCK_DETECT_EN
   logic            stuck;
`endif

   msk_rnd_feeder #(
      .d        (2),
      .NGADGETS (4),
      .IN_W     (IN_W)
   ) dut (
      .clk       (clk),
      .syn_rstn  (syn_rstn),
      .in_rnd    (in_rnd),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_req   (out_req),
      .out_rnd   (out_rnd),
      .out_valid (out_valid),
`ifdef RND_STUCK_DETECT_EN
      .stuck     (stuck),
`endif
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: buffer as a bit queue, front = oldest bit.
   bit mq[$];
   bit acc_log[$];
   bit cons_log[$];
   int m_st   = 0;   // 0: reset cycle, 1: priming, 2: serving
   bit m_uf   = 0;
   bit m_init = 0;
`ifdef RND_STUCK_DETECT_EN
   bit            m_stuck = 0;
   bit            m_have  = 0;
   int            m_run   = 0;
   logic [IN_W-1:0] m_last = '0;
`endif

   function automatic bit exp_rdy();
      return (m_st != 0) && (mq.size() + IN_W <= CW);
   endfunction

   function automatic bit exp_vld();
      return (m_st == 2) && (mq.size() >= OW);
   endfunction

   function automatic logic [OW-1:0] exp_word();
      logic [OW-1:0] w;
      w = '0;
      if (exp_vld())
         for (int i = 0; i < OW; i++) w[i] = mq[i];
      return w;
   endfunction

   always @(posedge clk) begin
      bit v, r;
      v = exp_vld();
      r = exp_rdy();
      m_init = 1'b1;
      if (!syn_rstn) begin
         mq.delete(); acc_log.delete(); cons_log.delete();
         m_st = 0;
         m_uf = 0;
`ifdef RND_STUCK_DETECT_EN
         m_stuck = 0; m_have = 0; m_run = 0;
`endif
      end else begin
         if (out_req && v)
            for (int i = 0; i < OW; i++) cons_log.push_back(mq.pop_front());
         if (in_valid && r) begin
            for (int i = 0; i < IN_W; i++) begin
               mq.push_back(in_rnd[i]);
               acc_log.push_back(in_rnd[i]);
            end
`ifdef RND_STUCK_DETECT_EN
            if (m_have && in_rnd == m_last) m_run++;
            else m_run = 1;
            m_have = 1;
            m_last = in_rnd;
            if (m_run >= 4) m_stuck = 1;
`endif
         end
         if (out_req && !v) m_uf = 1;
         if (m_st == 0) m_st = 1;
         else if (m_st == 1 && mq.size() > CW - IN_W) m_st = 2;
         else if (m_st == 2 && out_req && v && mq.size() < OW) m_st = 1;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("cyc_in_ready", 32'(in_ready), 32'(exp_rdy()));
         chk("cyc_out_valid", 32'(out_valid), 32'(exp_vld()));
         chk("cyc_out_rnd", 32'(out_rnd), 32'(exp_word()));
         chk("cyc_underflow", 32'(underflow), 32'(m_uf));
         chk("cyc_fill", 32'(dut.u_buf.fill_q), 32'(mq.size()));
`ifdef RND_STUCK_DETECT_EN
         chk("cyc_stuck", 32'(stuck), 32'(m_stuck));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat (serving words as they appear) until accepted, bounded.
   task automatic feed(input logic [IN_W-1:0] beat);
      bit done;
      done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         bit rdy;
         in_valid = 1'b1;
         in_rnd   = beat;
         out_req  = out_valid;
         rdy      = in_ready;
         step();
         done = rdy;
      end
      in_valid = 1'b0;
      out_req  = 1'b0;
      if (!done) chk("feed_timeout", 32'd0, 32'd1);
   endtask

   logic [IN_W-1:0] beats [3];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      bit ok;
      syn_rstn = 1'b0; in_valid = 1'b0; in_rnd = '0; out_req = 1'b0;
      step(); step();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_rnd", 32'(out_rnd), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);

      // Prime with 001, 010 (011 is held back because the buffer fills).
      beats[0] = 3'b001; beats[1] = 3'b010; beats[2] = 3'b011;
      syn_rstn = 1'b1;
      in_valid = 1'b1;
      idx = 0;
      repeat (4) begin
         bit rdy;
         in_rnd = beats[idx];
         rdy    = in_ready;
         step();
         if (rdy && idx < 2) idx++;
      end
      chk("prime_out_valid", 32'(out_valid), 32'd1);
      chk("prime_out_rnd", 32'(out_rnd), 32'b0001);
      chk("prime_in_ready", 32'(in_ready), 32'd0);
      chk("prime_fill", 32'(dut.u_buf.fill_q), 32'd6);
      chk("prime_model_fill", 32'(mq.size()), 32'd6);

      // Drain to 2 (back to priming), refill 011,100 to 8.
      in_valid = 1'b0; out_req = 1'b1; step(); out_req = 1'b0;
      chk("drain_fill", 32'(dut.u_buf.fill_q), 32'd2);
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b1; in_rnd = 3'b011; step();
      in_rnd = 3'b100; step(); in_valid = 1'b0;
      chk("refill_fill", 32'(dut.u_buf.fill_q), 32'd8);
      chk("refill_out_rnd", 32'(out_rnd), 32'b1101);
      out_req = 1'b1; step(); out_req = 1'b0;
      chk("cons_out_rnd", 32'(out_rnd), 32'b1000);
      chk("cons_fill", 32'(dut.u_buf.fill_q), 32'd4);

      // Push and consume together at fill 4: residue is exactly the new beat.
      in_valid = 1'b1; in_rnd = 3'b111; out_req = 1'b1; step();
      in_valid = 1'b0; out_req = 1'b0;
      chk("simul_fill", 32'(dut.u_buf.fill_q), 32'd3);
      chk("simul_bits", 32'(dut.u_buf.buf_q[2:0]), 32'b111);
      chk("simul_out_valid", 32'(out_valid), 32'd0);

      // Stream: consume whenever a word is offered.
      in_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         in_rnd  = IN_W'((i * 5 + 1) % 8);
         out_req = out_valid;
         step();
      end
      in_valid = 1'b0; out_req = 1'b0;
      ok = (cons_log.size() >= 32);
      for (int i = 0; i < cons_log.size(); i++)
         if (i >= acc_log.size() || cons_log[i] != acc_log[i]) ok = 0;
      chk("stream_order", 32'(ok), 32'd1);
      chk("stream_no_underflow", 32'(underflow), 32'd0);

      // Starve: keep requesting with no input.
      out_req = 1'b1;
      repeat (6) step();
      out_req = 1'b0;
      chk("starve_underflow", 32'(underflow), 32'd1);
      chk("starve_out_rnd", 32'(out_rnd), 32'd0);
      step(); step();
      chk("starve_sticky", 32'(underflow), 32'd1);

      // Reprime then reset mid-run.
      in_valid = 1'b1; in_rnd = 3'b010;
      repeat (3) step();
      in_valid = 1'b0;
      chk("rerun_out_valid", 32'(out_valid), 32'd1);
      syn_rstn = 1'b0; step();
      chk("mid_rst_fill", 32'(dut.u_buf.fill_q), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_underflow", 32'(underflow), 32'd0);
      syn_rstn = 1'b1; step();

`ifdef RND_STUCK_DETECT_EN
      repeat (3) feed(3'b101);
      chk("stuck_after3", 32'(stuck), 32'd0);
      feed(3'b101);
      chk("stuck_after4", 32'(stuck), 32'd1);
      syn_rstn = 1'b0; step(); syn_rstn = 1'b1; step();
      chk("stuck_rst", 32'(stuck), 32'd0);
      repeat (3) feed(3'b101);
      feed(3'b100);
      chk("stuck_broken_run", 32'(stuck), 32'd0);
`endif

      step(); step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
